// File: rtl/mt_next_pc.sv
// mt_next_pc: keeps one PC per hardware thread, resolves each thread's redirects by
// fixed priority, and round-robin arbitrates one fetch request per cycle to the IF stage.
// Ports: clk_i/rst_ni (async, active-high), per-thread boot/enable, the fetch valid/ready
// handshake (addr + tid), the bp/replay/mispredict/eret/trap/commit/debug redirect inputs,
// and thread_pc_o for observability.
// Latency: outputs are combinational from state (zero-cycle). Backpressure: with
// fetch_ready_i low, PCs and rr pointer hold; only a redirect can change the grant.
module mt_next_pc #(
  parameter int unsigned     VLEN             = 64,
  parameter int unsigned     FETCH_ALIGN_BITS = 3,
  parameter int unsigned     NR_THREADS       = 2,
  parameter int unsigned     TID_W            = (NR_THREADS > 1) ? $clog2(NR_THREADS) : 1,
  parameter logic [VLEN-1:0] DEBUG_PC         = VLEN'('h800)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NR_THREADS*VLEN-1:0] boot_addr_i,
  input  logic [NR_THREADS-1:0]      thread_en_i,
  output logic                       fetch_valid_o,
  input  logic                       fetch_ready_i,
  output logic [VLEN-1:0]            fetch_addr_o,
  output logic [TID_W-1:0]           fetch_tid_o,
  input  logic                       bp_valid_i,
  input  logic [TID_W-1:0]           bp_tid_i,
  input  logic [VLEN-1:0]            predict_address_i,
  input  logic [NR_THREADS-1:0]      replay_i,
  input  logic [NR_THREADS-1:0]      mispredict_i,
  input  logic [NR_THREADS-1:0]      eret_i,
  input  logic [NR_THREADS-1:0]      ex_valid_i,
  input  logic [NR_THREADS-1:0]      set_pc_commit_i,
  input  logic [NR_THREADS-1:0]      set_debug_pc_i,
  input  logic [NR_THREADS-1:0]      halt_i,
  input  logic [NR_THREADS*VLEN-1:0] replay_addr_i,
  input  logic [NR_THREADS*VLEN-1:0] target_address_mispredict_i,
  input  logic [NR_THREADS*VLEN-1:0] eret_pc_i,
  input  logic [NR_THREADS*VLEN-1:0] trap_vector_base_i,
  input  logic [NR_THREADS*VLEN-1:0] pc_commit_i,
  output logic [NR_THREADS*VLEN-1:0] thread_pc_o
);

  localparam int unsigned BLK_W = VLEN - FETCH_ALIGN_BITS;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                             state_q [NR_THREADS];
  state_e                             state_d [NR_THREADS];
  logic   [NR_THREADS-1:0][VLEN-1:0]  pc_q;
  logic   [NR_THREADS-1:0][VLEN-1:0]  pc_d;
  logic   [NR_THREADS-1:0][VLEN-1:0]  eff;
  logic   [NR_THREADS-1:0][VLEN-1:0]  seq_pc;
  logic   [NR_THREADS-1:0]            bp_hit;
  logic   [NR_THREADS-1:0]            redirected;
  logic   [NR_THREADS-1:0]            eligible;
  logic   [TID_W-1:0]                 rr_q;
  logic   [TID_W-1:0]                 rr_d;
  logic   [TID_W-1:0]                 grant;
  logic                               any_elig;
  logic                               handshake;

  // Effective PC, redirect detection and eligibility per thread.
  // A redirected thread is masked from arbitration so a stale address is never fetched.
  always_comb begin
    for (int unsigned t = 0; t < NR_THREADS; t++) begin
      eff[t]        = (state_q[t] == ST_BOOT) ? boot_addr_i[t*VLEN +: VLEN] : pc_q[t];
      bp_hit[t]     = bp_valid_i && (bp_tid_i == TID_W'(t));
      redirected[t] = set_debug_pc_i[t] | set_pc_commit_i[t] | ex_valid_i[t] | eret_i[t]
                    | mispredict_i[t] | replay_i[t] | bp_hit[t];
      eligible[t]   = thread_en_i[t] & ~redirected[t];
      // Next fetch block: drop the offset within the block, step one block (wraps).
      seq_pc[t]     = {eff[t][VLEN-1:FETCH_ALIGN_BITS] + BLK_W'(1), {FETCH_ALIGN_BITS{1'b0}}};
    end
  end

  // Round-robin arbiter: first eligible thread at or after rr_q, modulo NR_THREADS.
  always_comb begin
    any_elig = 1'b0;
    grant    = '0;
    for (int unsigned k = 0; k < NR_THREADS; k++) begin
      if (!any_elig && eligible[(32'(rr_q) + k) % NR_THREADS]) begin
        any_elig = 1'b1;
        grant    = TID_W'((32'(rr_q) + k) % NR_THREADS);
      end
    end
  end

  assign handshake = any_elig & fetch_ready_i;

  // Pointer moves past the granted thread only when the request is actually taken.
  always_comb begin
    rr_d = rr_q;
    if (handshake) begin
      rr_d = (grant == TID_W'(NR_THREADS - 1)) ? '0 : grant + TID_W'(1);
    end
  end

  // Next-state logic: BOOT is left on the first edge after reset, whatever happens
  // that cycle (the boot address is folded into eff), and RUN is absorbing.
  always_comb begin
    for (int unsigned t = 0; t < NR_THREADS; t++) begin
      state_d[t] = ST_RUN;
    end
  end

  // Next PC per thread; highest-priority redirect first, then sequential advance,
  // otherwise hold eff (which in BOOT latches the boot address into pc_q).
  always_comb begin
    for (int unsigned t = 0; t < NR_THREADS; t++) begin
      if (set_debug_pc_i[t]) begin
        pc_d[t] = DEBUG_PC;
      end else if (set_pc_commit_i[t]) begin
        // A halted commit re-executes the same instruction, so no step.
        pc_d[t] = pc_commit_i[t*VLEN +: VLEN] + (halt_i[t] ? VLEN'(0) : VLEN'(4));
      end else if (ex_valid_i[t]) begin
        pc_d[t] = trap_vector_base_i[t*VLEN +: VLEN];
      end else if (eret_i[t]) begin
        pc_d[t] = eret_pc_i[t*VLEN +: VLEN];
      end else if (mispredict_i[t]) begin
        pc_d[t] = target_address_mispredict_i[t*VLEN +: VLEN];
      end else if (replay_i[t]) begin
        pc_d[t] = replay_addr_i[t*VLEN +: VLEN];
      end else if (bp_hit[t]) begin
        pc_d[t] = predict_address_i;
      end else if (handshake && (grant == TID_W'(t))) begin
        pc_d[t] = seq_pc[t];
      end else begin
        pc_d[t] = eff[t];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      pc_q <= '0;
      rr_q <= '0;
      for (int unsigned t = 0; t < NR_THREADS; t++) begin
        state_q[t] <= ST_BOOT;
      end
    end else begin
      pc_q <= pc_d;
      rr_q <= rr_d;
      for (int unsigned t = 0; t < NR_THREADS; t++) begin
        state_q[t] <= state_d[t];
      end
    end
  end

  // Outputs are forced quiet while reset is held so in-flight requests drop at once.
  always_comb begin
    fetch_valid_o = 1'b0;
    fetch_addr_o  = '0;
    fetch_tid_o   = '0;
    thread_pc_o   = '0;
    if (!rst_ni) begin
      fetch_valid_o = any_elig;
      fetch_addr_o  = eff[grant];
      fetch_tid_o   = grant;
      thread_pc_o   = pc_q;
    end
  end

endmodule

// File: tb/tb_mt_next_pc.sv
module tb_mt_next_pc;
  localparam int N  = 2;
  localparam int VL = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N*VL-1:0] boot_addr_i;
  logic [N-1:0]    thread_en_i;
  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic [VL-1:0]   fetch_addr_o;
  logic [0:0]      fetch_tid_o;
  logic            bp_valid_i;
  logic [0:0]      bp_tid_i;
  logic [VL-1:0]   predict_address_i;
  logic [N-1:0]    replay_i, mispredict_i, eret_i, ex_valid_i, set_pc_commit_i, set_debug_pc_i, halt_i;
  logic [N*VL-1:0] replay_addr_i, target_address_mispredict_i, eret_pc_i, trap_vector_base_i, pc_commit_i;
  logic [N*VL-1:0] thread_pc_o;

  mt_next_pc dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i), .thread_en_i(thread_en_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i), .fetch_addr_o(fetch_addr_o),
    .fetch_tid_o(fetch_tid_o), .bp_valid_i(bp_valid_i), .bp_tid_i(bp_tid_i),
    .predict_address_i(predict_address_i), .replay_i(replay_i), .mispredict_i(mispredict_i),
    .eret_i(eret_i), .ex_valid_i(ex_valid_i), .set_pc_commit_i(set_pc_commit_i),
    .set_debug_pc_i(set_debug_pc_i), .halt_i(halt_i), .replay_addr_i(replay_addr_i),
    .target_address_mispredict_i(target_address_mispredict_i), .eret_pc_i(eret_pc_i),
    .trap_vector_base_i(trap_vector_base_i), .pc_commit_i(pc_commit_i), .thread_pc_o(thread_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: per-thread PC, "has left boot" flag and next-to-serve pointer.
  logic [VL-1:0] m_pc [N];
  bit            m_run [N];
  int            m_rr;
  bit            exp_valid;
  int            exp_tid;
  logic [VL-1:0] exp_addr;

  function automatic logic [VL-1:0] m_eff(int t);
    return m_run[t] ? m_pc[t] : boot_addr_i[t*VL +: VL];
  endfunction

  function automatic bit m_redir(int t);
    return set_debug_pc_i[t] || set_pc_commit_i[t] || ex_valid_i[t] || eret_i[t] ||
           mispredict_i[t] || replay_i[t] || (bp_valid_i && int'(bp_tid_i) == t);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      m_pc[t]  = '0;
      m_run[t] = 1'b0;
    end
    m_rr = 0;
  endtask

  task automatic model_outputs();
    exp_valid = 1'b0;
    exp_tid   = 0;
    exp_addr  = '0;
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        int t;
        t = (m_rr + k) % N;
        if (!exp_valid && thread_en_i[t] && !m_redir(t)) begin
          exp_valid = 1'b1;
          exp_tid   = t;
          exp_addr  = m_eff(t);
        end
      end
    end
  endtask

  function automatic logic [N*VL-1:0] m_thread_pc();
    logic [N*VL-1:0] v;
    for (int t = 0; t < N; t++) v[t*VL +: VL] = m_pc[t];
    return v;
  endfunction

  task automatic model_update();
    bit hs;
    logic [VL-1:0] e, n;
    model_outputs();
    if (rst_ni) begin
      model_reset();
      return;
    end
    hs = exp_valid && fetch_ready_i;
    for (int t = 0; t < N; t++) begin
      e = m_eff(t);
      if (set_debug_pc_i[t])        n = 64'h800;
      else if (set_pc_commit_i[t])  n = pc_commit_i[t*VL +: VL] + (halt_i[t] ? 64'd0 : 64'd4);
      else if (ex_valid_i[t])       n = trap_vector_base_i[t*VL +: VL];
      else if (eret_i[t])           n = eret_pc_i[t*VL +: VL];
      else if (mispredict_i[t])     n = target_address_mispredict_i[t*VL +: VL];
      else if (replay_i[t])         n = replay_addr_i[t*VL +: VL];
      else if (bp_valid_i && int'(bp_tid_i) == t) n = predict_address_i;
      else if (hs && exp_tid == t)  n = (e & ~64'h7) + 64'd8;
      else                          n = e;
      m_pc[t]  = n;
      m_run[t] = 1'b1;
    end
    if (hs) m_rr = (exp_tid + 1) % N;
  endtask

  // Advance the model with the inputs as they stand at the coming edge, then the DUT.
  task automatic step();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_redirects();
    bp_valid_i = 0; bp_tid_i = 0; predict_address_i = '0;
    replay_i = '0; mispredict_i = '0; eret_i = '0; ex_valid_i = '0;
    set_pc_commit_i = '0; set_debug_pc_i = '0; halt_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    clear_redirects();
    replay_addr_i = '0; target_address_mispredict_i = '0; eret_pc_i = '0;
    trap_vector_base_i = '0; pc_commit_i = '0;
    boot_addr_i = {64'h9000_0000, 64'h8000_0000};
    thread_en_i = 2'b11;
    fetch_ready_i = 1'b1;
    model_reset();
    step();
    step();
    vectors++;
    if (fetch_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %0b want 0", fetch_valid_o);
    end
    vectors++;
    if (fetch_addr_o !== 64'h0 || fetch_tid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_addr_tid got %h/%0d want 0/0", fetch_addr_o, fetch_tid_o);
    end
    vectors++;
    if (thread_pc_o !== '0) begin
      miscompares++; $display("FAIL reset_thread_pc got %h want 0", thread_pc_o);
    end
  endtask

  task automatic test_boot();
    logic [VL-1:0] want_addr [4];
    int            want_tid [4];
    want_addr[0] = 64'h8000_0000; want_tid[0] = 0;
    want_addr[1] = 64'h9000_0000; want_tid[1] = 1;
    want_addr[2] = 64'h8000_0008; want_tid[2] = 0;
    want_addr[3] = 64'h9000_0008; want_tid[3] = 1;
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (fetch_valid_o !== 1'b1 || fetch_addr_o !== want_addr[i] || int'(fetch_tid_o) != want_tid[i]) begin
        miscompares++;
        $display("FAIL boot_seq[%0d] got v=%0b t%0d@%h want v=1 t%0d@%h", i, fetch_valid_o,
                 fetch_tid_o, fetch_addr_o, want_tid[i], want_addr[i]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    step();  // t0 @ 0x8000_0010 taken, pointer now at t1
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (fetch_valid_o !== 1'b1 || fetch_tid_o !== 1'b1 || fetch_addr_o !== 64'h9000_0010) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got v=%0b t%0d@%h want v=1 t1@90000010", i,
                 fetch_valid_o, fetch_tid_o, fetch_addr_o);
      end
      vectors++;
      if (thread_pc_o !== {64'h9000_0010, 64'h8000_0018}) begin
        miscompares++; $display("FAIL stall_pc[%0d] got %h want 9000001080000018", i, thread_pc_o);
      end
      step();
    end
    fetch_ready_i = 1'b1;
    step();
    vectors++;
    if (thread_pc_o[VL +: VL] !== 64'h9000_0018) begin
      miscompares++; $display("FAIL stall_release got %h want 90000018", thread_pc_o[VL +: VL]);
    end
  endtask

  task automatic test_priority();
    fetch_ready_i = 1'b0;
    replay_i[0] = 1'b1; replay_addr_i[0 +: VL] = 64'h1000;
    step();
    clear_redirects();
    ex_valid_i[0] = 1'b1; trap_vector_base_i[0 +: VL] = 64'h200;
    mispredict_i[0] = 1'b1; target_address_mispredict_i[0 +: VL] = 64'h3000;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b1 || fetch_tid_o !== 1'b1) begin
      miscompares++; $display("FAIL prio_mask got v=%0b t%0d want v=1 t1", fetch_valid_o, fetch_tid_o);
    end
    step();
    clear_redirects();
    thread_en_i = 2'b01;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b1 || fetch_tid_o !== 1'b0 || fetch_addr_o !== 64'h200) begin
      miscompares++; $display("FAIL prio_target got v=%0b t%0d@%h want v=1 t0@200",
                              fetch_valid_o, fetch_tid_o, fetch_addr_o);
    end
  endtask

  task automatic test_commit();
    logic [VL-1:0] want [3];
    want[0] = 64'h4004; want[1] = 64'h4000; want[2] = 64'h800;
    fetch_ready_i = 1'b0;
    thread_en_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      clear_redirects();
      set_pc_commit_i[0] = 1'b1; pc_commit_i[0 +: VL] = 64'h4000;
      halt_i[0] = (i == 1);
      set_debug_pc_i[0] = (i == 2);
      #1;
      vectors++;
      if (fetch_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL commit_mask[%0d] got v=%0b want 0", i, fetch_valid_o);
      end
      step();
      clear_redirects();
      #1;
      vectors++;
      if (fetch_addr_o !== want[i] || fetch_valid_o !== 1'b1) begin
        miscompares++; $display("FAIL commit_addr[%0d] got v=%0b @%h want v=1 @%h", i,
                                fetch_valid_o, fetch_addr_o, want[i]);
      end
    end
  endtask

  task automatic test_park();
    fetch_ready_i = 1'b1;
    thread_en_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      clear_redirects();
      if (i == 1) begin
        replay_i[1] = 1'b1; replay_addr_i[VL +: VL] = 64'h5000;
      end
      #1;
      vectors++;
      if (fetch_valid_o !== 1'b1 || fetch_tid_o !== 1'b0) begin
        miscompares++; $display("FAIL park_only_t0[%0d] got v=%0b t%0d want v=1 t0", i,
                                fetch_valid_o, fetch_tid_o);
      end
      step();
    end
    clear_redirects();
    thread_en_i = 2'b11;
    #1;
    vectors++;
    if (fetch_tid_o !== 1'b1 || fetch_addr_o !== 64'h5000) begin
      miscompares++; $display("FAIL park_replay got t%0d@%h want t1@5000", fetch_tid_o, fetch_addr_o);
    end
    step();
  endtask

  task automatic test_wrap();
    fetch_ready_i = 1'b0;
    thread_en_i = 2'b01;
    clear_redirects();
    replay_i[0] = 1'b1; replay_addr_i[0 +: VL] = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    clear_redirects();
    fetch_ready_i = 1'b1;
    #1;
    vectors++;
    if (fetch_addr_o !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      miscompares++; $display("FAIL wrap_pre got %h want fffffffffffffff8", fetch_addr_o);
    end
    step();
    vectors++;
    if (thread_pc_o[0 +: VL] !== 64'h0 || fetch_addr_o !== 64'h0) begin
      miscompares++; $display("FAIL wrap_post got pc=%h addr=%h want 0/0", thread_pc_o[0 +: VL], fetch_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    thread_en_i = 2'b11;
    fetch_ready_i = 1'b1;
    clear_redirects();
    step();
    step();
    rst_ni = 1'b1;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b0 || thread_pc_o !== '0) begin
      miscompares++; $display("FAIL midreset_quiet got v=%0b pc=%h want 0/0", fetch_valid_o, thread_pc_o);
    end
    model_reset();
    step();
    boot_addr_i = {64'hB000_0000, 64'hA000_0000};
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b1 || fetch_tid_o !== 1'b0 || fetch_addr_o !== 64'hA000_0000) begin
      miscompares++; $display("FAIL midreset_reboot0 got v=%0b t%0d@%h want v=1 t0@a0000000",
                              fetch_valid_o, fetch_tid_o, fetch_addr_o);
    end
    step();
    vectors++;
    if (fetch_tid_o !== 1'b1 || fetch_addr_o !== 64'hB000_0000) begin
      miscompares++; $display("FAIL midreset_reboot1 got t%0d@%h want t1@b0000000", fetch_tid_o, fetch_addr_o);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      thread_en_i   = 2'($urandom);
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      bp_valid_i    = ($urandom_range(0, 7) == 0);
      bp_tid_i      = 1'($urandom);
      predict_address_i = {$urandom, $urandom};
      for (int t = 0; t < N; t++) begin
        replay_i[t]        = ($urandom_range(0, 15) == 0);
        mispredict_i[t]    = ($urandom_range(0, 15) == 0);
        eret_i[t]          = ($urandom_range(0, 15) == 0);
        ex_valid_i[t]      = ($urandom_range(0, 15) == 0);
        set_pc_commit_i[t] = ($urandom_range(0, 15) == 0);
        set_debug_pc_i[t]  = ($urandom_range(0, 31) == 0);
        halt_i[t]          = 1'($urandom);
        replay_addr_i[t*VL +: VL]               = {$urandom, $urandom};
        target_address_mispredict_i[t*VL +: VL] = {$urandom, $urandom};
        eret_pc_i[t*VL +: VL]                   = {$urandom, $urandom};
        trap_vector_base_i[t*VL +: VL]          = {$urandom, $urandom};
        pc_commit_i[t*VL +: VL]                 = {$urandom, $urandom};
      end
      #1;
      model_outputs();
      vectors++;
      if (fetch_valid_o !== exp_valid ||
          (exp_valid && (fetch_addr_o !== exp_addr || int'(fetch_tid_o) != exp_tid))) begin
        miscompares++;
        $display("FAIL rand_fetch[%0d] got v=%0b t%0d@%h want v=%0b t%0d@%h", i, fetch_valid_o,
                 fetch_tid_o, fetch_addr_o, exp_valid, exp_tid, exp_addr);
      end
      vectors++;
      if (thread_pc_o !== m_thread_pc()) begin
        miscompares++; $display("FAIL rand_pc[%0d] got %h want %h", i, thread_pc_o, m_thread_pc());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_priority();
    test_commit();
    test_park();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
